// File: rtl/sd_cmd_frame_receiver_if.sv
// rtl/sd_cmd_frame_receiver_if.sv - CMD line input and decoded-frame output bundle
interface sd_cmd_frame_receiver_if;
    logic        iEnable;
    logic        iCmd;
    logic [5:0]  oIndex;
    logic [31:0] oArgument;
    logic        oValid;
    logic        oFrameError;
    logic        oCrcError;
    logic        oBusy;

    modport master (
        output iEnable, iCmd,
        input  oIndex, oArgument, oValid, oFrameError, oCrcError, oBusy
    );

    modport slave (
        input  iEnable, iCmd,
        output oIndex, oArgument, oValid, oFrameError, oCrcError, oBusy
    );
endinterface

// File: rtl/sd_cmd_frame_receiver.sv
// rtl/sd_cmd_frame_receiver.sv - SD CMD 48-bit frame receiver; CRC7 check enabled by SD_CMD_RX_CRC_EN
module sd_cmd_frame_receiver #(
    parameter logic EXPECT_DIR = 1'b1
) (
    input  logic iClock_SD,
    input  logic iReset,
    sd_cmd_frame_receiver_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [46:0] shift_q, shift_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        frame_bad;

`ifdef SD_CMD_RX_CRC_EN
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  crc_next;
    logic        crc_fb;
    logic        cerr_q, cerr_d;

    // Start bit is 0 and init is 0, so feeding only bits 46..8 gives the same CRC.
    assign crc_fb   = crc_q[6] ^ bus.iCmd;
    assign crc_next = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
`endif

    // shift_q holds frame bits 46..0 once the end bit is in.
    assign frame_bad = (shift_q[46] != EXPECT_DIR) || !shift_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SD_CMD_RX_CRC_EN
        crc_d   = crc_q;
        cerr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.iEnable && !bus.iCmd) begin
                    state_d = ST_RECV;
                    cnt_d   = 6'd1;
`ifdef SD_CMD_RX_CRC_EN
                    crc_d   = 7'h00;
`endif
                end
            end
            ST_RECV: begin
                if (!bus.iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_d = {shift_q[45:0], bus.iCmd};
                    cnt_d   = cnt_q + 6'd1;
`ifdef SD_CMD_RX_CRC_EN
                    if (cnt_q <= 6'd39) begin
                        crc_d = crc_next;
                    end
`endif
                    if (cnt_q == 6'd47) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!bus.iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (frame_bad) begin
                        ferr_d = 1'b1;
`ifdef SD_CMD_RX_CRC_EN
                    end else if (crc_q != shift_q[7:1]) begin
                        cerr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        idx_d   = shift_q[45:40];
                        arg_d   = shift_q[39:8];
                    end
                    // A low sample here is already the next frame's start bit.
                    if (!bus.iCmd) begin
                        state_d = ST_RECV;
                        cnt_d   = 6'd1;
`ifdef SD_CMD_RX_CRC_EN
                        crc_d   = 7'h00;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock_SD or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            shift_q <= 47'd0;
            idx_q   <= 6'd0;
            arg_q   <= 32'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef SD_CMD_RX_CRC_EN
    always_ff @(posedge iClock_SD or negedge iReset) begin
        if (!iReset) begin
            crc_q  <= 7'h00;
            cerr_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            cerr_q <= cerr_d;
        end
    end

    assign bus.oCrcError = cerr_q;
`else
    assign bus.oCrcError = 1'b0;
`endif

    assign bus.oIndex      = idx_q;
    assign bus.oArgument   = arg_q;
    assign bus.oValid      = valid_q;
    assign bus.oFrameError = ferr_q;
    assign bus.oBusy       = (state_q != ST_IDLE);
endmodule
